// File: rtl/lfsr_stream_checker_if.sv
// -----------------------------------------------------------------------------
// lfsr_stream_checker_if
// Groups the LFSR sample stream and the checker status outputs into one bundle.
//   valid        : q carries a new LFSR state word this cycle
//   q[5:0]       : LFSR state word
//   locked       : checker is in LOCKED
//   err          : one-cycle pulse per mismatching sample while locked
//   err_cnt[7:0] : saturating count of locked mismatches
//   period[6:0]  : last measured seed-to-seed distance in valid samples
//   period_valid : sticky, set once the first period has been measured
// Modports:
//   master : LFSR side / observer (drives the stream, reads the status)
//   slave  : the checker (reads the stream, drives the status)
// -----------------------------------------------------------------------------
interface lfsr_stream_checker_if;
    logic       valid;
    logic [5:0] q;
    logic       locked;
    logic       err;
    logic [7:0] err_cnt;
    logic [6:0] period;
    logic       period_valid;

    modport master (
        output valid, q,
        input  locked, err, err_cnt, period, period_valid
    );

    modport slave (
        input  valid, q,
        output locked, err, err_cnt, period, period_valid
    );
endinterface

// File: rtl/lfsr_stream_checker.sv
// -----------------------------------------------------------------------------
// lfsr_stream_checker
// Self-check for the 6-bit set-to-ones Galois LFSR. Each valid sample is
// compared against the prediction made from the previous sample. A run of
// LOCK_THRESH correct predictions declares lock; while locked, mismatches are
// flagged and counted, LOSS_THRESH consecutive mismatches drop lock, and the
// distance between successive SEED occurrences is measured.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset, clears all state immediately
//   bus : lfsr_stream_checker_if.slave (valid/q in, status out)
// Parameters:
//   SEED        : word the LFSR loads on reset, period reference point
//   LOCK_THRESH : consecutive correct predictions to lock (1..15)
//   LOSS_THRESH : consecutive locked mispredictions to drop lock (1..15)
// -----------------------------------------------------------------------------
module lfsr_stream_checker #(
    parameter logic [5:0]  SEED        = 6'h3F,
    parameter int unsigned LOCK_THRESH = 4,
    parameter int unsigned LOSS_THRESH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    lfsr_stream_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [4:0] LOCK_TH5 = 5'(LOCK_THRESH);
    localparam logic [4:0] LOSS_TH5 = 5'(LOSS_THRESH);

    // Galois next-state function of the upstream generator.
    function automatic logic [5:0] lfsr_nxt(input logic [5:0] x);
        logic [5:0] n;
        n[0] = x[5];
        n[1] = x[0];
        n[2] = x[1] ^ x[5];
        n[3] = x[2];
        n[4] = x[3] ^ x[5];
        n[5] = x[4] ^ x[5];
        return n;
    endfunction

    state_t     state_q, state_d;
    logic [5:0] exp_q, exp_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic [3:0] miss_cnt_q, miss_cnt_d;
    logic [6:0] per_cnt_q, per_cnt_d;
    logic       seen_seed_q, seen_seed_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [6:0] period_q, period_d;
    logic       period_valid_q, period_valid_d;

    logic       match_s;
    logic [5:0] q_nxt_s;
    logic [4:0] run_inc_s;
    logic [4:0] miss_inc_s;

    // All-zero is the LFSR lockup word, so it never counts as a match.
    assign match_s    = (bus.q == exp_q) && (bus.q != 6'd0);
    assign q_nxt_s    = lfsr_nxt(bus.q);
    // One bit wider than the counters so the threshold compare cannot wrap.
    assign run_inc_s  = {1'b0, run_cnt_q} + 5'd1;
    assign miss_inc_s = {1'b0, miss_cnt_q} + 5'd1;

    // Next-state, counter and status computation for one sample.
    always_comb begin
        state_d        = state_q;
        exp_d          = exp_q;
        run_cnt_d      = run_cnt_q;
        miss_cnt_d     = miss_cnt_q;
        per_cnt_d      = per_cnt_q;
        seen_seed_d    = seen_seed_q;
        err_d          = 1'b0;
        err_cnt_d      = err_cnt_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;

        if (bus.valid) begin
            // Every state resyncs the prediction to the observed word.
            exp_d = q_nxt_s;
            case (state_q)
                ST_IDLE: begin
                    run_cnt_d = 4'd0;
                    state_d   = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (match_s) begin
                        run_cnt_d = run_inc_s[3:0];
                        if (run_inc_s == LOCK_TH5) begin
                            state_d     = ST_LOCKED;
                            miss_cnt_d  = 4'd0;
                            per_cnt_d   = 7'd0;
                            seen_seed_d = 1'b0;
                        end else begin
                            state_d = ST_ACQUIRE;
                        end
                    end else begin
                        run_cnt_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (match_s) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        err_d      = 1'b1;
                        err_cnt_d  = (err_cnt_q == 8'hFF) ? 8'hFF : (err_cnt_q + 8'd1);
                        miss_cnt_d = miss_inc_s[3:0];
                        if (miss_inc_s == LOSS_TH5) begin
                            state_d   = ST_ACQUIRE;
                            run_cnt_d = 4'd0;
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end

                    // Seed sightings restart the measurement even when the
                    // seed sample itself was mispredicted.
                    if (bus.q == SEED) begin
                        per_cnt_d = 7'd0;
                        if (seen_seed_q) begin
                            period_d       = (per_cnt_q == 7'h7F) ? 7'h7F : (per_cnt_q + 7'd1);
                            period_valid_d = 1'b1;
                        end else begin
                            seen_seed_d = 1'b1;
                        end
                    end else begin
                        per_cnt_d = (per_cnt_q == 7'h7F) ? 7'h7F : (per_cnt_q + 7'd1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and status registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            exp_q          <= 6'd0;
            run_cnt_q      <= 4'd0;
            miss_cnt_q     <= 4'd0;
            per_cnt_q      <= 7'd0;
            seen_seed_q    <= 1'b0;
            locked_q       <= 1'b0;
            err_q          <= 1'b0;
            err_cnt_q      <= 8'd0;
            period_q       <= 7'd0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            exp_q          <= exp_d;
            run_cnt_q      <= run_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            per_cnt_q      <= per_cnt_d;
            seen_seed_q    <= seen_seed_d;
            locked_q       <= locked_d;
            err_q          <= err_d;
            err_cnt_q      <= err_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign bus.locked       = locked_q;
    assign bus.err          = err_q;
    assign bus.err_cnt      = err_cnt_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;

endmodule

// File: doc/lfsr_stream_checker.md
# lfsr_stream_checker

Downstream consumer of the 6-bit set-to-ones Galois LFSR stage. It samples the LFSR state word each valid cycle, predicts the next state from the fixed feedback function and acquires lock after a run of correct predictions. Once locked it flags and counts mismatches and measures the sequence period between successive seed occurrences. It sits between the LFSR and the status/debug logic, as the self-check for the generator.

## Interface
- SEED, 6'h3F, state the upstream LFSR loads on reset; period measurement reference point
- LOCK_THRESH, 4, consecutive correct predictions required to declare lock (1..15)
- LOSS_THRESH, 3, consecutive mispredictions in LOCKED that drop lock (1..15)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- valid  input  1  q carries a new LFSR state this cycle
- q  input  6  LFSR state word
- locked  output  1  registered; high while in LOCKED
- err  output  1  registered one-cycle pulse per mismatching sample while LOCKED
- err_cnt  output  8  mismatches counted while LOCKED, saturates at 255
- period  output  7  last measured seed-to-seed distance in valid samples
- period_valid  output  1  sticky once the first period has been measured

## Operation
- Next-state function nxt(x): n[0]=x[5]; n[1]=x[0]; n[2]=x[1]^x[5]; n[3]=x[2]; n[4]=x[3]^x[5]; n[5]=x[4]^x[5].
- Internal state: state register, exp (6b), run_cnt (4b), miss_cnt (4b), per_cnt (7b), seen_seed (1b).
- A sample matches iff q==exp and q!=0. All-zero is the lockup state and is always a mismatch.
- valid low: every register holds, and err is low.
- IDLE: on valid, exp<=nxt(q), run_cnt<=0, go to ACQUIRE.
- ACQUIRE, valid:
  - match: exp<=nxt(q), run_cnt++. If run_cnt+1==LOCK_THRESH, go to LOCKED, miss_cnt<=0, per_cnt<=0, seen_seed<=0.
  - mismatch: exp<=nxt(q) (resync to the observed word), run_cnt<=0.
  - No err pulses and no err_cnt change in ACQUIRE.
- LOCKED, valid:
  - Always exp<=nxt(q).
  - match: miss_cnt<=0.
  - mismatch: err<=1, err_cnt saturating-increment, miss_cnt++. If miss_cnt+1==LOSS_THRESH, go to ACQUIRE, run_cnt<=0.
- Period measurement, LOCKED only, on valid samples:
  - per_cnt saturating-increments at 127.
  - If q==SEED and seen_seed: period<=per_cnt+1 (saturating at 127), period_valid<=1, per_cnt<=0.
  - If q==SEED and !seen_seed: seen_seed<=1, per_cnt<=0.
  - A seed sample that is also a mismatch still restarts the measurement.
- Leaving LOCKED keeps period, period_valid and err_cnt unchanged.

## Timing
- Reset values, asynchronous: state=IDLE, locked=0, err=0, err_cnt=0, period=0, period_valid=0, exp=0, run_cnt=0, miss_cnt=0, per_cnt=0, seen_seed=0.
- Reset asserted mid-operation clears everything the same cycle, without waiting for a clock edge. The first valid after release is treated as an IDLE sample.
- Latency: err, locked, err_cnt, period and period_valid all update on the rising edge that samples the triggering valid q, so they are visible one cycle after it.
- Continuous valid from an upstream sequence starting at SEED: locked rises after sample index LOCK_THRESH, counting the first sample as 0.
- The lock-threshold and loss-threshold conditions evaluate on the same edge as their counter update; there is no extra cycle.

## Test plan
- Reset: hold rst high with random valid/q → every output 0. Release, then drive valid=0 for 10 cycles → outputs stay 0 and the state stays IDLE.
- Acquire: valid stream 3F,0B,16,2C,2D → locked=1 one cycle after 2D, err never high, err_cnt=0.
- Single error: lock as above, inject one wrong word (00 in place of the expected next word), then resume the true sequence from nxt(00 position's true value) → one err pulse, err_cnt=1, locked stays 1. The next true sample also mismatches because exp=nxt(00)=00 → err_cnt=2, and the stream then re-tracks.
- Loss of lock: after lock, drive 3 consecutive random non-matching words → 3 err pulses, err_cnt=3, locked falls one cycle after the third. Replaying 3F,0B,16,2C,2D relocks.
- Period: drive the bench reference-model LFSR from SEED continuously, with valid toggled randomly → period equals the model's seed-to-seed count, period_valid rises on the second post-lock seed occurrence, and period is unchanged across valid-low gaps.
- Saturation/async reset: force more than 255 locked mismatches using LOSS_THRESH=15 with alternating good/bad words → err_cnt holds at 255. Assert rst between clock edges → all outputs 0 before the next edge.
